// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - VRAM port arbiter: fixed video read slot per character, queued CPU writes elsewhere
// Optional feature macro: VRAM_ARB_COALESCE_EN (merge a write into the newest unissued entry at the same address)
module vram_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        pixClock,
  input  logic        reset,
  input  logic [2:0]  seq,
  input  logic        fetchEn,
  input  logic [14:0] vidAddr,
  output logic        vidLatch,
  input  logic        wrReq,
  input  logic [14:0] wrAddr,
  input  logic [7:0]  wrData,
  output logic        wrAck,
  output logic [14:0] vramAddr,
  output logic [7:0]  vramDataOut,
  output logic        nvramWE,
  output logic        nvramOE,
  output logic [2:0]  fifoLevel
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, GUARD} state_t;

  state_t        state;
  state_t        nextState;
  logic [14:0]   addrMem [FIFO_DEPTH];
  logic [7:0]    dataMem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          popNow;
  logic          pushNow;

  assign full      = (level == FULL_LEVEL);
  assign empty     = (level == '0);
  assign fifoLevel = 3'(level);
  assign vidLatch  = (state == READ);

  // Slot selection: the video read and its turnaround cycle always win; writes fill the rest
  always_comb begin
    nextState = IDLE;
    if (fetchEn && seq == 3'd7)
      nextState = READ;
    else if (fetchEn && seq == 3'd6)
      nextState = GUARD;
    else if (!empty)
      nextState = WRITE;
  end

  assign popNow = (nextState == WRITE);

`ifdef VRAM_ARB_COALESCE_EN
  logic [PW-1:0] newestIdx;
  logic          coalesceHit;

  // A hit only counts while the newest entry stays queued past this edge
  assign newestIdx   = wrPtr - PW'(1);
  assign coalesceHit = wrReq && !empty && (addrMem[newestIdx] == wrAddr)
                       && !(popNow && rdPtr == newestIdx);
  assign wrAck       = wrReq && !reset && (coalesceHit || !full);
  assign pushNow     = wrAck && !coalesceHit;
`else
  assign wrAck   = wrReq && !full && !reset;
  assign pushNow = wrAck;
`endif

  // Queue storage: new entries land at the tail; a coalesced write refreshes the tail's data
  always_ff @(negedge pixClock) begin
    if (pushNow) begin
      addrMem[wrPtr] <= wrAddr;
      dataMem[wrPtr] <= wrData;
    end
`ifdef VRAM_ARB_COALESCE_EN
    else if (coalesceHit) begin
      dataMem[newestIdx] <= wrData;
    end
`endif
  end

  // Arbiter state, queue bookkeeping and registered VRAM pin drive
  always_ff @(negedge pixClock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wrPtr       <= '0;
      rdPtr       <= '0;
      level       <= '0;
      vramAddr    <= '0;
      vramDataOut <= '0;
      nvramWE     <= 1'b1;
      nvramOE     <= 1'b1;
    end else begin
      state <= nextState;
      if (pushNow)
        wrPtr <= wrPtr + PW'(1);
      if (popNow)
        rdPtr <= rdPtr + PW'(1);
      case ({pushNow, popNow})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      case (nextState)
        READ: begin
          vramAddr    <= vidAddr;
          vramDataOut <= '0;
          nvramWE     <= 1'b1;
          nvramOE     <= 1'b0;
        end
        WRITE: begin
          vramAddr    <= addrMem[rdPtr];
          vramDataOut <= dataMem[rdPtr];
          nvramWE     <= 1'b0;
          nvramOE     <= 1'b1;
        end
        default: begin
          vramDataOut <= '0;
          nvramWE     <= 1'b1;
          nvramOE     <= 1'b1;
        end
      endcase
    end
  end

endmodule
